// File: rtl/minterm_sweeper.sv
// minterm_sweeper: steps a 4-input function through all 16 input vectors,
// captures its truth table and scores it against a golden minterm mask.
module minterm_sweeper #(
    parameter logic [15:0] EXPECTED = 16'hA5F5,
    parameter int unsigned SETTLE   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        A,
    output logic        B,
    output logic        C,
    output logic        D,
    input  logic        O,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] mask,
    output logic [4:0]  mismatches,
    output logic [3:0]  fail_idx
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_HOLD   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // Last settle count before sampling; unused when SETTLE is 0.
    localparam logic [3:0] HOLD_LAST = 4'((SETTLE == 0) ? 0 : SETTLE - 1);
    // With no settle time every vector goes straight to sampling.
    localparam logic [1:0] S_VEC = (SETTLE == 0) ? S_SAMPLE : S_HOLD;

    logic [1:0]  r_state;
    logic [3:0]  r_idx;
    logic [3:0]  r_cnt;
    logic [15:0] r_mask;
    logic [4:0]  r_mism;
    logic [3:0]  r_fidx;
    logic        r_pass;

    logic        w_busy;
    logic        w_miss;

    assign w_busy = (r_state == S_HOLD) || (r_state == S_SAMPLE);
    assign w_miss = (O != EXPECTED[r_idx]);

    // Stimulus is only presented while a sweep is running.
    assign {A, B, C, D} = w_busy ? r_idx : 4'd0;
    assign busy         = w_busy;
    assign done         = (r_state == S_DONE);
    assign pass         = r_pass;
    assign mask         = r_mask;
    assign mismatches   = r_mism;
    assign fail_idx     = r_fidx;

    // Sweep sequencer: settle, sample, score, advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= 4'd0;
            r_mask  <= 16'd0;
            r_mism  <= 5'd0;
            r_fidx  <= 4'd0;
            r_pass  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state <= S_VEC;
                        r_idx   <= 4'd0;
                        r_cnt   <= 4'd0;
                        r_mask  <= 16'd0;
                        r_mism  <= 5'd0;
                        r_fidx  <= 4'd0;
                        r_pass  <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_state <= S_SAMPLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                S_SAMPLE: begin
                    r_mask[r_idx] <= O;
                    if (w_miss) begin
                        if (r_mism != 5'd16) begin
                            r_mism <= r_mism + 5'd1;
                        end
                        if (r_mism == 5'd0) begin
                            r_fidx <= r_idx;
                        end
                    end
                    if (r_idx == 4'd15) begin
                        r_state <= S_DONE;
                        r_pass  <= (r_mism == 5'd0) && !w_miss;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_cnt   <= 4'd0;
                        r_state <= S_VEC;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_minterm_sweeper.sv
// tb_minterm_sweeper: scoreboarded bench for minterm_sweeper,
// one DUT with SETTLE=1 and one with SETTLE=0.
module tb_minterm_sweeper;

    localparam logic [15:0] GOLD = 16'hA5F5;

    typedef struct packed {
        logic [15:0] mask;
        logic [4:0]  mism;
        logic [3:0]  fidx;
        logic        pass;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic st1 = 1'b0;
    logic st0 = 1'b0;
    int   mode = 0;

    logic a1, b1, c1, d1, o1, busy1, done1, pass1;
    logic [15:0] mask1;
    logic [4:0]  mism1;
    logic [3:0]  fidx1;
    logic a0, b0, c0, d0, o0, busy0, done0, pass0;
    logic [15:0] mask0;
    logic [4:0]  mism0;
    logic [3:0]  fidx0;

    res_t q[$];
    logic [3:0] trace [0:63];
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    minterm_sweeper #(.EXPECTED(GOLD), .SETTLE(1)) u_s1 (
        .clk(clk), .rst(rst), .start(st1),
        .A(a1), .B(b1), .C(c1), .D(d1), .O(o1),
        .busy(busy1), .done(done1), .pass(pass1),
        .mask(mask1), .mismatches(mism1), .fail_idx(fidx1)
    );

    minterm_sweeper #(.EXPECTED(GOLD), .SETTLE(0)) u_s0 (
        .clk(clk), .rst(rst), .start(st0),
        .A(a0), .B(b0), .C(c0), .D(d0), .O(o0),
        .busy(busy0), .done(done0), .pass(pass0),
        .mask(mask0), .mismatches(mism0), .fail_idx(fidx0)
    );

    // Function under test: 0 golden SOP, 1 wrong SOP, 2 stuck-0, 3 stuck-1.
    function automatic logic fut(input int m, input logic [3:0] v);
        logic a, b, c, d;
        {a, b, c, d} = v;
        case (m)
            0: fut = (!b && !d) || (!a && b) || (b && d);
            1: fut = (!a && !b && !c && !d) || (a && !c && !d) ||
                     (!b && c && !d) || (!a && b && c && d) ||
                     (b && !c && d);
            2: fut = 1'b0;
            default: fut = 1'b1;
        endcase
    endfunction

    function automatic res_t model(input int m);
        res_t r;
        bit   first;
        r = '0;
        first = 1'b1;
        for (int i = 0; i < 16; i++) begin
            r.mask[i] = fut(m, 4'(i));
            if (r.mask[i] != GOLD[i]) begin
                r.mism = r.mism + 5'd1;
                if (first) r.fidx = 4'(i);
                first = 1'b0;
            end
        end
        r.pass = (r.mism == 5'd0);
        return r;
    endfunction

    always_comb o1 = fut(mode, {a1, b1, c1, d1});
    always_comb o0 = fut(mode, {a0, b0, c0, d0});

    // Pulse start, then count cycles until done (bounded). Optional
    // extra start pulses while busy and on the final sample edge.
    task automatic run_sweep(input bit sel, input bit poke,
                             output int cyc, output int nbusy);
        cyc = 0;
        nbusy = 0;
        @(negedge clk);
        if (sel) st1 = 1'b1; else st0 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        st0 = 1'b0;
        while (cyc < 200) begin
            if (sel) st1 = poke && (cyc == 10 || cyc == 20 || cyc == 31);
            if (cyc < 64)
                trace[cyc] = sel ? {a1, b1, c1, d1} : {a0, b0, c0, d0};
            if (sel ? done1 : done0) break;
            if (sel ? busy1 : busy0) nbusy++;
            @(negedge clk);
            cyc++;
        end
        st1 = 1'b0;
    endtask

    task automatic pop_exp(output res_t e);
        if (q.size() == 0) begin
            e = 'x;
        end else begin
            e = q.pop_front();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy1, done1, pass1, mask1, mism1, fidx1, a1, b1, c1, d1} !== '0) begin
            n_bad++;
            $display("FAIL reset_s1 got busy=%b done=%b mask=%h mism=%0d abcd=%b%b%b%b want all 0",
                     busy1, done1, mask1, mism1, a1, b1, c1, d1);
        end
        n_vec++;
        if ({busy0, done0, pass0, mask0, mism0, fidx0, a0, b0, c0, d0} !== '0) begin
            n_bad++;
            $display("FAIL reset_s0 got busy=%b done=%b mask=%h mism=%0d want all 0",
                     busy0, done0, mask0, mism0);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy1, done1, busy0, done0} !== 4'b0) begin
            n_bad++;
            $display("FAIL idle_hold got busy1=%b done1=%b busy0=%b done0=%b want 0",
                     busy1, done1, busy0, done0);
        end
    endtask

    task automatic test_golden;
        int cyc, nb;
        res_t e, o;
        mode = 0;
        q.push_back(model(0));
        run_sweep(1'b1, 1'b0, cyc, nb);
        pop_exp(e);
        o = {mask1, mism1, fidx1, pass1};
        n_vec++;
        if (o !== e || done1 !== 1'b1) begin
            n_bad++;
            $display("FAIL golden_res got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
                     o.mask, o.mism, o.fidx, o.pass, e.mask, e.mism, e.fidx, e.pass);
        end
        n_vec++;
        if (o !== {16'hA5F5, 5'd0, 4'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL golden_const got mask=%h mism=%0d pass=%b want a5f5/0/1",
                     o.mask, o.mism, o.pass);
        end
        n_vec++;
        if (cyc !== 32) begin
            n_bad++;
            $display("FAIL golden_latency got %0d want 32", cyc);
        end
        n_vec++;
        if (nb !== 32) begin
            n_bad++;
            $display("FAIL golden_busy got %0d want 32", nb);
        end
    endtask

    task automatic test_wrong_sop;
        int cyc, nb;
        res_t e, o;
        mode = 1;
        q.push_back(model(1));
        run_sweep(1'b1, 1'b0, cyc, nb);
        pop_exp(e);
        o = {mask1, mism1, fidx1, pass1};
        n_vec++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL wrong_res got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
                     o.mask, o.mism, o.fidx, o.pass, e.mask, e.mism, e.fidx, e.pass);
        end
        n_vec++;
        if (o !== {16'h35A5, 5'd4, 4'd4, 1'b0}) begin
            n_bad++;
            $display("FAIL wrong_const got %h/%0d/%0d/%b want 35a5/4/4/0",
                     o.mask, o.mism, o.fidx, o.pass);
        end
    endtask

    task automatic test_stuck0;
        int cyc, nb;
        res_t e, o;
        mode = 2;
        q.push_back(model(2));
        run_sweep(1'b1, 1'b0, cyc, nb);
        pop_exp(e);
        o = {mask1, mism1, fidx1, pass1};
        n_vec++;
        if (o !== e || o !== {16'h0000, 5'd10, 4'd0, 1'b0}) begin
            n_bad++;
            $display("FAIL stuck0_res got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
                     o.mask, o.mism, o.fidx, o.pass, e.mask, e.mism, e.fidx, e.pass);
        end
    endtask

    task automatic test_latency;
        int cyc, nb;
        res_t e, o;
        mode = 0;
        q.push_back(model(0));
        run_sweep(1'b0, 1'b0, cyc, nb);
        pop_exp(e);
        o = {mask0, mism0, fidx0, pass0};
        n_vec++;
        if (cyc !== 16) begin
            n_bad++;
            $display("FAIL s0_latency got %0d want 16", cyc);
        end
        for (int i = 0; i < 16; i++) begin
            n_vec++;
            if (trace[i] !== 4'(i)) begin
                n_bad++;
                $display("FAIL s0_abcd[%0d] got %b want %b", i, trace[i], 4'(i));
            end
        end
        n_vec++;
        if (o !== e) begin
            n_bad++;
            $display("FAIL s0_res got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
                     o.mask, o.mism, o.fidx, o.pass, e.mask, e.mism, e.fidx, e.pass);
        end
    endtask

    task automatic test_reset_mid;
        int cyc, nb, k;
        res_t e, o;
        mode = 0;
        q.push_back(model(0));
        @(negedge clk);
        st1 = 1'b1;
        @(negedge clk);
        st1 = 1'b0;
        k = 0;
        while ({a1, b1, c1, d1} != 4'd7 && k < 100) begin
            @(negedge clk);
            k++;
        end
        n_vec++;
        if (k >= 100) begin
            n_bad++;
            $display("FAIL mid_reach_idx7 got timeout want idx 7");
        end
        rst = 1'b1;
        @(negedge clk);
        void'(q.pop_back());
        n_vec++;
        if ({busy1, done1, mask1, mism1, a1, b1, c1, d1} !== '0) begin
            n_bad++;
            $display("FAIL mid_reset got busy=%b done=%b mask=%h mism=%0d abcd=%b%b%b%b want 0",
                     busy1, done1, mask1, mism1, a1, b1, c1, d1);
        end
        rst = 1'b0;
        q.push_back(model(0));
        run_sweep(1'b1, 1'b0, cyc, nb);
        pop_exp(e);
        o = {mask1, mism1, fidx1, pass1};
        n_vec++;
        if (o !== e || cyc !== 32) begin
            n_bad++;
            $display("FAIL mid_resweep got %h/%0d/%0d/%b cyc=%0d want %h/%0d/%0d/%b cyc=32",
                     o.mask, o.mism, o.fidx, o.pass, cyc, e.mask, e.mism, e.fidx, e.pass);
        end
    endtask

    task automatic test_back_to_back;
        int cyc, nb;
        res_t e, o;
        mode = 0;
        q.push_back(model(0));
        run_sweep(1'b1, 1'b1, cyc, nb);
        pop_exp(e);
        o = {mask1, mism1, fidx1, pass1};
        n_vec++;
        if (o !== e || cyc !== 32) begin
            n_bad++;
            $display("FAIL poke_res got %h/%0d/%0d/%b cyc=%0d want %h/%0d/%0d/%b cyc=32",
                     o.mask, o.mism, o.fidx, o.pass, cyc, e.mask, e.mism, e.fidx, e.pass);
        end
        @(negedge clk);
        n_vec++;
        if (done1 !== 1'b1 || busy1 !== 1'b0) begin
            n_bad++;
            $display("FAIL final_edge_start got done=%b busy=%b want done=1 busy=0",
                     done1, busy1);
        end
        mode = 3;
        q.push_back(model(3));
        run_sweep(1'b1, 1'b0, cyc, nb);
        pop_exp(e);
        o = {mask1, mism1, fidx1, pass1};
        n_vec++;
        if (o !== e || o !== {16'hFFFF, 5'd6, 4'd1, 1'b0}) begin
            n_bad++;
            $display("FAIL restart_s1 got %h/%0d/%0d/%b want %h/%0d/%0d/%b",
                     o.mask, o.mism, o.fidx, o.pass, e.mask, e.mism, e.fidx, e.pass);
        end
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_left got %0d want 0", q.size());
        end
    endtask

    initial begin
        test_reset();
        test_golden();
        test_wrong_sop();
        test_stuck0();
        test_latency();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/minterm_sweeper.md
MINTERM_SWEEPER -- requirements
Module: minterm_sweeper

Interface
REQ-001 Parameter: EXPECTED, default 16'hA5F5, golden minterm mask; bit i is the required O for input vector i, where i = {A,B,C,D} and A is the MSB.
REQ-002 Parameter: SETTLE, default 1, number of extra cycles each vector is held before O is sampled (range 0..15).
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous and active-high.
REQ-005 Port: start  input  1  request to begin a sweep.
REQ-006 Port: A, B, C, D  output  1 each  stimulus driven to the 4-input function under test.
REQ-007 Port: O  input  1  response from the function under test.
REQ-008 Port: busy  output  1  high while a sweep is running.
REQ-009 Port: done  output  1  high while results are valid.
REQ-010 Port: pass  output  1  high when the captured mask equals EXPECTED; meaningful only while done=1.
REQ-011 Port: mask  output  16  captured truth table of O.
REQ-012 Port: mismatches  output  5  count of bits where mask differs from EXPECTED (0..16).
REQ-013 Port: fail_idx  output  4  lowest mismatching vector index; 0 when there is no mismatch.

Function
REQ-014 The FSM SHALL have the states IDLE, HOLD, SAMPLE and DONE.
REQ-015 IDLE or DONE with start=1 SHALL go to HOLD on the next edge, with idx=0, settle counter=0, mask=0, mismatches=0, fail_idx=0, done=0 and pass=0.
REQ-016 start SHALL be ignored in HOLD and SAMPLE.
REQ-017 In HOLD and SAMPLE, {A,B,C,D} SHALL equal idx.
REQ-018 In IDLE and DONE, {A,B,C,D} SHALL equal 4'b0000.
REQ-019 HOLD SHALL last exactly SETTLE cycles; it SHALL be skipped when SETTLE=0, so that start goes directly to SAMPLE.
REQ-020 HOLD SHALL then go to SAMPLE.
REQ-021 SAMPLE SHALL last one cycle; at its closing edge, mask[idx] SHALL be set to O.
REQ-022 At that same SAMPLE edge, if O != EXPECTED[idx], mismatches SHALL increment by 1.
REQ-023 At that same SAMPLE edge, if O != EXPECTED[idx] and this is the first mismatch of the sweep, fail_idx SHALL load idx.
REQ-024 SAMPLE with idx<15 SHALL increment idx, clear the settle counter, and go to HOLD (or stay in SAMPLE when SETTLE=0).
REQ-025 SAMPLE with idx=15 SHALL go to DONE; idx SHALL not wrap.
REQ-026 A sweep SHALL take exactly 16*(SETTLE+1) cycles from the first cycle after start to the first cycle of DONE.
REQ-027 busy SHALL be 1 exactly in HOLD and SAMPLE.
REQ-028 done SHALL be 1 exactly in DONE, held until rst or a new start.
REQ-029 pass SHALL be registered on entry to DONE as (mismatches==0), including the final sample.
REQ-030 mask, mismatches and fail_idx SHALL hold their final values throughout DONE.
REQ-031 A start asserted on the same edge as the final SAMPLE SHALL be ignored.
REQ-032 mismatches SHALL saturate at 16; because at most 16 samples occur, no overflow is possible.
REQ-033 O SHALL be sampled only in SAMPLE; it is a don't-care in all other states.

Reset
REQ-034 rst=1 at an edge SHALL force IDLE, with idx=0, settle counter=0, and A=B=C=D=0.
REQ-035 rst=1 at an edge SHALL clear busy, done, pass, mask, mismatches and fail_idx to 0.
REQ-036 rst SHALL take priority over start and over any in-progress sweep; rst asserted mid-sweep SHALL abandon the sweep with no partial results retained.
REQ-037 After rst deasserts, the block SHALL remain in IDLE until start=1.

Verification
REQ-038 Golden case: with SETTLE=1 and O driven by B'D'+A'B+BD from {A,B,C,D}, pulse start -> busy for 32 cycles, then done=1, pass=1, mask=16'hA5F5, mismatches=0, fail_idx=0.
REQ-039 Wrong SOP case: O = A'B'C'D'+AC'D'+B'CD'+A'BCD+BC'D -> mask=16'h35A5, mismatches=4, fail_idx=4, pass=0.
REQ-040 Stuck-at-0 case: O tied to 0 -> mask=16'h0000, mismatches=10, fail_idx=0, pass=0.
REQ-041 Latency case: SETTLE=0 with the golden function -> done rises exactly 16 cycles after the start edge; {A,B,C,D} steps 0..15, one value per cycle.
REQ-042 Reset mid-sweep: assert rst at idx=7 -> next cycle busy=0, done=0, mask=0, A..D=0; a subsequent start performs a full 32-cycle sweep with correct results.
REQ-043 start ignored / restart: pulsing start while busy changes nothing (completion time and results unchanged); start in DONE with O stuck-at-1 -> a new sweep with mask=16'hFFFF, mismatches=6, fail_idx=1.
